// File: rtl/vram_map_pkg.sv
// VRAM write-port address map, region and window-FSM types shared by the
// write router and the readback path.
package vram_map_pkg;

    localparam logic [12:0] TILE_BASE = 13'h0000;
    localparam logic [12:0] PAT_BASE  = 13'h0800;
    localparam logic [12:0] PAL_BASE  = 13'h1800;
    localparam logic [12:0] SPR_BASE  = 13'h1A00;
    localparam logic [12:0] SPR_LAST  = 13'h1A27;

    localparam int TILE_AW  = 11;
    localparam int PAT_AW   = 12;
    localparam int PAL_AW   = 9;
    localparam int SPR_AW   = 6;
    localparam int LOCAL_AW = 12;

    typedef enum logic [2:0] {
        REG_TILE = 3'd0,
        REG_PAT  = 3'd1,
        REG_PAL  = 3'd2,
        REG_SPR  = 3'd3,
        REG_OOB  = 3'd4
    } vram_region_t;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_IRQ    = 2'd1,
        ST_OPEN   = 2'd2
    } win_state_t;

endpackage

// File: rtl/vram_addr_decode.sv
// Combinational decode of a 13-bit VRAM word address into a region and the
// region-local address (zero when out of bounds).
module vram_addr_decode
    import vram_map_pkg::*;
(
    input  logic [12:0]         addr,
    output vram_region_t        region,
    output logic [LOCAL_AW-1:0] local_addr
);

    // Ordered range compare; anything above the sprite table is out of bounds.
    always_comb begin
        region     = REG_OOB;
        local_addr = 12'h000;
        if (addr < PAT_BASE) begin
            region     = REG_TILE;
            local_addr = {1'b0, addr[10:0]};
        end else if (addr < PAL_BASE) begin
            region     = REG_PAT;
            local_addr = 12'(addr - PAT_BASE);
        end else if (addr < SPR_BASE) begin
            region     = REG_PAL;
            local_addr = 12'(addr - PAL_BASE);
        end else if (addr <= SPR_LAST) begin
            region     = REG_SPR;
            local_addr = 12'(addr - SPR_BASE);
        end else begin
            region     = REG_OOB;
            local_addr = 12'h000;
        end
    end

endmodule

// File: rtl/vram_write_router.sv
// Per-frame VRAM write window: raises the CPU interrupt at vblank_start,
// routes h2f writes to tile/pattern/palette/sprite RAM one cycle later.
module vram_write_router
    import vram_map_pkg::*;
#(
    parameter int DROP_CNT_W = 16,
    parameter int IRQ_LEN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vblank_start,
    input  logic                  vblank_end,
    input  logic                  cpu_wr_busy,
    input  logic [12:0]           h2f_vram_wraddr,
    input  logic                  h2f_vram_wren,
    input  logic [63:0]           h2f_vram_wrdata,
    input  logic [7:0]            h2f_vram_byteena,
    output logic                  cpu_vram_wr_irq,
    output logic                  window_open,
    output logic [TILE_AW-1:0]    tile_wraddr,
    output logic                  tile_wren,
    output logic [PAT_AW-1:0]     pat_wraddr,
    output logic                  pat_wren,
    output logic [PAL_AW-1:0]     pal_wraddr,
    output logic                  pal_wren,
    output logic [SPR_AW-1:0]     spr_wraddr,
    output logic                  spr_wren,
    output logic [63:0]           vram_wrdata,
    output logic [7:0]            vram_byteena,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  err_oob,
    output logic                  err_overrun
);

    localparam logic [3:0] IRQ_LEN_C = 4'(IRQ_LEN);

    vram_region_t        region_s;
    logic [LOCAL_AW-1:0] local_addr_s;
    logic                accept_s;
    logic                drop_s;

    win_state_t          state_q, state_d;
    logic [3:0]          irq_cnt_q, irq_cnt_d;
    logic                irq_q, irq_d;
    logic                window_q, window_d;
    logic                tile_wren_q, tile_wren_d;
    logic                pat_wren_q, pat_wren_d;
    logic                pal_wren_q, pal_wren_d;
    logic                spr_wren_q, spr_wren_d;
    logic [TILE_AW-1:0]  tile_addr_q, tile_addr_d;
    logic [PAT_AW-1:0]   pat_addr_q, pat_addr_d;
    logic [PAL_AW-1:0]   pal_addr_q, pal_addr_d;
    logic [SPR_AW-1:0]   spr_addr_q, spr_addr_d;
    logic [63:0]         wrdata_q, wrdata_d;
    logic [7:0]          byteena_q, byteena_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                err_oob_q, err_oob_d;
    logic                err_overrun_q, err_overrun_d;

    vram_addr_decode u_decode (
        .addr       (h2f_vram_wraddr),
        .region     (region_s),
        .local_addr (local_addr_s)
    );

    // Window FSM next state; acceptance uses the current registered state.
    always_comb begin
        state_d   = state_q;
        irq_cnt_d = irq_cnt_q;
        irq_d     = irq_q;
        window_d  = window_q;
        case (state_q)
            ST_CLOSED: begin
                if (vblank_start) begin
                    state_d   = ST_IRQ;
                    irq_cnt_d = IRQ_LEN_C;
                    irq_d     = 1'b1;
                    window_d  = 1'b1;
                end else begin
                    irq_d    = 1'b0;
                    window_d = 1'b0;
                end
            end
            ST_IRQ: begin
                if (vblank_end) begin
                    state_d  = ST_CLOSED;
                    irq_d    = 1'b0;
                    window_d = 1'b0;
                end else if (irq_cnt_q <= 4'd1) begin
                    state_d  = ST_OPEN;
                    irq_d    = 1'b0;
                end else begin
                    irq_cnt_d = irq_cnt_q - 4'd1;
                end
            end
            ST_OPEN: begin
                if (vblank_end) begin
                    state_d  = ST_CLOSED;
                    window_d = 1'b0;
                end else begin
                    window_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_CLOSED;
                irq_d    = 1'b0;
                window_d = 1'b0;
            end
        endcase
    end

    // Write routing, drop accounting and sticky error flags.
    always_comb begin
        accept_s      = h2f_vram_wren && (state_q != ST_CLOSED) && (region_s != REG_OOB);
        drop_s        = h2f_vram_wren && ((state_q == ST_CLOSED) || (region_s == REG_OOB));
        tile_wren_d   = accept_s && (region_s == REG_TILE);
        pat_wren_d    = accept_s && (region_s == REG_PAT);
        pal_wren_d    = accept_s && (region_s == REG_PAL);
        spr_wren_d    = accept_s && (region_s == REG_SPR);
        tile_addr_d   = tile_addr_q;
        pat_addr_d    = pat_addr_q;
        pal_addr_d    = pal_addr_q;
        spr_addr_d    = spr_addr_q;
        wrdata_d      = wrdata_q;
        byteena_d     = byteena_q;
        if (h2f_vram_wren) begin
            tile_addr_d = local_addr_s[TILE_AW-1:0];
            pat_addr_d  = local_addr_s[PAT_AW-1:0];
            pal_addr_d  = local_addr_s[PAL_AW-1:0];
            spr_addr_d  = local_addr_s[SPR_AW-1:0];
            wrdata_d    = h2f_vram_wrdata;
            byteena_d   = h2f_vram_byteena;
        end else begin
            wrdata_d    = wrdata_q;
        end
        drop_cnt_d = drop_cnt_q;
        if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        err_oob_d     = err_oob_q | (h2f_vram_wren && (region_s == REG_OOB));
        err_overrun_d = err_overrun_q |
                        (vblank_end && cpu_wr_busy && (state_q != ST_CLOSED));
    end

    // All state and outputs registered; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_CLOSED;
            irq_cnt_q     <= 4'd0;
            irq_q         <= 1'b0;
            window_q      <= 1'b0;
            tile_wren_q   <= 1'b0;
            pat_wren_q    <= 1'b0;
            pal_wren_q    <= 1'b0;
            spr_wren_q    <= 1'b0;
            tile_addr_q   <= '0;
            pat_addr_q    <= '0;
            pal_addr_q    <= '0;
            spr_addr_q    <= '0;
            wrdata_q      <= 64'd0;
            byteena_q     <= 8'd0;
            drop_cnt_q    <= '0;
            err_oob_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_cnt_q     <= irq_cnt_d;
            irq_q         <= irq_d;
            window_q      <= window_d;
            tile_wren_q   <= tile_wren_d;
            pat_wren_q    <= pat_wren_d;
            pal_wren_q    <= pal_wren_d;
            spr_wren_q    <= spr_wren_d;
            tile_addr_q   <= tile_addr_d;
            pat_addr_q    <= pat_addr_d;
            pal_addr_q    <= pal_addr_d;
            spr_addr_q    <= spr_addr_d;
            wrdata_q      <= wrdata_d;
            byteena_q     <= byteena_d;
            drop_cnt_q    <= drop_cnt_d;
            err_oob_q     <= err_oob_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign cpu_vram_wr_irq = irq_q;
    assign window_open     = window_q;
    assign tile_wraddr     = tile_addr_q;
    assign tile_wren       = tile_wren_q;
    assign pat_wraddr      = pat_addr_q;
    assign pat_wren        = pat_wren_q;
    assign pal_wraddr      = pal_addr_q;
    assign pal_wren        = pal_wren_q;
    assign spr_wraddr      = spr_addr_q;
    assign spr_wren        = spr_wren_q;
    assign vram_wrdata     = wrdata_q;
    assign vram_byteena    = byteena_q;
    assign drop_count      = drop_cnt_q;
    assign err_oob         = err_oob_q;
    assign err_overrun     = err_overrun_q;

endmodule

// File: tb/tb_vram_write_router.sv
// Directed bench for vram_write_router: expected RAM writes go through a
// scoreboard queue and are matched against the region enables as they appear.
module tb_vram_write_router;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblank_start = 1'b0;
    logic        vblank_end = 1'b0;
    logic        cpu_wr_busy = 1'b0;
    logic [12:0] h2f_vram_wraddr = 13'd0;
    logic        h2f_vram_wren = 1'b0;
    logic [63:0] h2f_vram_wrdata = 64'd0;
    logic [7:0]  h2f_vram_byteena = 8'd0;
    logic        cpu_vram_wr_irq, window_open;
    logic [10:0] tile_wraddr;
    logic [11:0] pat_wraddr;
    logic [8:0]  pal_wraddr;
    logic [5:0]  spr_wraddr;
    logic        tile_wren, pat_wren, pal_wren, spr_wren;
    logic [63:0] vram_wrdata;
    logic [7:0]  vram_byteena;
    logic [3:0]  drop_count;
    logic        err_oob, err_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          region;
        logic [11:0] loc;
        logic [63:0] data;
        logic [7:0]  be;
    } exp_t;
    exp_t sb_q[$];

    vram_write_router #(.DROP_CNT_W(4), .IRQ_LEN(1)) dut (
        .clk(clk), .rst_n(rst_n), .vblank_start(vblank_start), .vblank_end(vblank_end),
        .cpu_wr_busy(cpu_wr_busy), .h2f_vram_wraddr(h2f_vram_wraddr),
        .h2f_vram_wren(h2f_vram_wren), .h2f_vram_wrdata(h2f_vram_wrdata),
        .h2f_vram_byteena(h2f_vram_byteena), .cpu_vram_wr_irq(cpu_vram_wr_irq),
        .window_open(window_open), .tile_wraddr(tile_wraddr), .tile_wren(tile_wren),
        .pat_wraddr(pat_wraddr), .pat_wren(pat_wren), .pal_wraddr(pal_wraddr),
        .pal_wren(pal_wren), .spr_wraddr(spr_wraddr), .spr_wren(spr_wren),
        .vram_wrdata(vram_wrdata), .vram_byteena(vram_byteena),
        .drop_count(drop_count), .err_oob(err_oob), .err_overrun(err_overrun)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One write on the h2f port; accepted writes are queued for the monitor.
    task automatic wr(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be,
                      input bit ok, input int rg, input logic [11:0] loc);
        exp_t e;
        h2f_vram_wraddr  = a;
        h2f_vram_wrdata  = d;
        h2f_vram_byteena = be;
        h2f_vram_wren    = 1'b1;
        if (ok) begin
            e.region = rg; e.loc = loc; e.data = d; e.be = be;
            sb_q.push_back(e);
        end
        tick();
        h2f_vram_wren = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Region-enable monitor: every enable must match the head of the scoreboard.
    always @(negedge clk) begin
        int nw;
        int rg;
        logic [11:0] loc;
        exp_t e;
        nw  = int'(tile_wren) + int'(pat_wren) + int'(pal_wren) + int'(spr_wren);
        rg  = 0;
        loc = 12'd0;
        if (tile_wren) begin rg = 0; loc = {1'b0, tile_wraddr}; end
        if (pat_wren)  begin rg = 1; loc = pat_wraddr; end
        if (pal_wren)  begin rg = 2; loc = {3'd0, pal_wraddr}; end
        if (spr_wren)  begin rg = 3; loc = {6'd0, spr_wraddr}; end
        if (nw > 0) begin
            chk("one_wren", 64'(nw), 64'd1);
            chk("wren_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("region", 64'(rg), 64'(e.region));
                chk("local_addr", 64'(loc), 64'(e.loc));
                chk("wrdata", vram_wrdata, e.data);
                chk("byteena", 64'(vram_byteena), 64'(e.be));
            end
        end
    end

    logic [12:0] b_addr [8] = '{13'h0000, 13'h07FF, 13'h0800, 13'h17FF,
                                13'h1800, 13'h19FF, 13'h1A00, 13'h1A27};
    int          b_reg  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic [11:0] b_loc  [8] = '{12'h000, 12'h7FF, 12'h000, 12'hFFF,
                                12'h000, 12'h1FF, 12'h000, 12'h027};

    initial begin
        // Reset values
        #5;
        chk("rst_irq", 64'(cpu_vram_wr_irq), 64'd0);
        chk("rst_window", 64'(window_open), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_errs", 64'({err_oob, err_overrun}), 64'd0);
        do_reset();

        // Closed-window writes are dropped
        for (int i = 0; i < 3; i++) wr(13'h0000, 64'd7, 8'hFF, 1'b0, 0, 12'd0);
        tick();
        chk("closed_drop", 64'(drop_count), 64'd3);
        chk("closed_window", 64'(window_open), 64'd0);

        // vblank_start with a simultaneous write: window opens, write dropped
        vblank_start = 1'b1;
        wr(13'h0010, 64'd9, 8'hFF, 1'b0, 0, 12'd0);
        vblank_start = 1'b0;
        chk("irq_first", 64'(cpu_vram_wr_irq), 64'd1);
        chk("win_first", 64'(window_open), 64'd1);
        chk("vbs_write_drop", 64'(drop_count), 64'd4);
        // A write during the IRQ cycle is accepted
        wr(13'h0123, 64'hA5A5, 8'h0F, 1'b1, 0, 12'h123);
        chk("irq_done", 64'(cpu_vram_wr_irq), 64'd0);
        chk("win_open", 64'(window_open), 64'd1);

        // Boundary decode, back to back
        for (int i = 0; i < 8; i++) wr(b_addr[i], 64'd12345, 8'hFF, 1'b1, b_reg[i], b_loc[i]);
        wr(13'h0400, 64'hDEAD_BEEF_0000_0001, 8'h00, 1'b1, 0, 12'h400);
        tick();
        chk("map_no_drop", 64'(drop_count), 64'd4);
        chk("map_no_oob", 64'(err_oob), 64'd0);

        // Out of bounds while open
        wr(13'h1A28, 64'd1, 8'hFF, 1'b0, 0, 12'd0);
        wr(13'h1FFF, 64'd2, 8'hFF, 1'b0, 0, 12'd0);
        tick();
        chk("oob_drop", 64'(drop_count), 64'd6);
        chk("oob_flag", 64'(err_oob), 64'd1);

        // Write in the vblank_end cycle is accepted; window falls next cycle
        repeat (20) tick();
        vblank_end = 1'b1;
        wr(13'h1A05, 64'h5555, 8'h3C, 1'b1, 3, 12'h005);
        vblank_end = 1'b0;
        chk("vbe_window", 64'(window_open), 64'd0);
        chk("vbe_no_overrun", 64'(err_overrun), 64'd0);
        chk("vbe_drop", 64'(drop_count), 64'd6);

        // Collision from CLOSED, then overrun
        do_reset();
        vblank_start = 1'b1;
        vblank_end   = 1'b1;
        tick();
        vblank_start = 1'b0;
        vblank_end   = 1'b0;
        chk("coll_window", 64'(window_open), 64'd1);
        chk("coll_irq", 64'(cpu_vram_wr_irq), 64'd1);
        tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        chk("vbs_ignored_irq", 64'(cpu_vram_wr_irq), 64'd0);
        cpu_wr_busy = 1'b1;
        vblank_end  = 1'b1;
        tick();
        vblank_end  = 1'b0;
        cpu_wr_busy = 1'b0;
        chk("ovr_window", 64'(window_open), 64'd0);
        chk("ovr_flag", 64'(err_overrun), 64'd1);

        // Saturation
        do_reset();
        for (int i = 0; i < 20; i++) wr(13'(i), 64'(i), 8'hFF, 1'b0, 0, 12'd0);
        tick();
        chk("sat_drop", 64'(drop_count), 64'd15);

        // Asynchronous reset mid-window with a write in flight
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        tick();
        h2f_vram_wraddr = 13'h0002;
        h2f_vram_wren   = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wren", 64'({tile_wren, pat_wren, pal_wren, spr_wren}), 64'd0);
        chk("arst_window", 64'(window_open), 64'd0);
        chk("arst_drop", 64'(drop_count), 64'd0);
        chk("arst_err", 64'({err_oob, err_overrun}), 64'd0);
        tick();
        h2f_vram_wren = 1'b0;
        rst_n = 1'b1;
        tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        chk("reopen_window", 64'(window_open), 64'd1);
        chk("reopen_irq", 64'(cpu_vram_wr_irq), 64'd1);
        wr(13'h1900, 64'h77, 8'h81, 1'b1, 2, 12'h100);
        tick();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_write_router.md
Name: vram_write_router

Overview:
- PPU-side receiver for the HPS-to-FPGA VRAM write port.
- Opens a write window once per frame at vblank_start and raises cpu_vram_wr_irq so the CPU starts its write burst.
- Decodes each 13-bit h2f word address into tile, pattern, palette or sprite RAM and drives that RAM's write port one cycle later.
- Drops and counts writes outside the window or outside the address map; closes the window at vblank_end.

Parameters:
- DROP_CNT_W, 16: width of the saturating dropped-write counter.
- IRQ_LEN, 1: cpu_vram_wr_irq pulse length in clk cycles, range 1..15.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- vblank_start  in  1  single-cycle pulse, clk domain
- vblank_end  in  1  single-cycle pulse, clk domain
- cpu_wr_busy  in  1  CPU write burst still in progress
- h2f_vram_wraddr  in  13  VRAM word address
- h2f_vram_wren  in  1  write strobe, one word per cycle
- h2f_vram_wrdata  in  64  write data
- h2f_vram_byteena  in  8  byte enables
- cpu_vram_wr_irq  out  1  write-window interrupt
- window_open  out  1  high while writes are accepted
- tile_wraddr  out  11  tile RAM address
- tile_wren  out  1  tile RAM write enable
- pat_wraddr  out  12  pattern RAM address
- pat_wren  out  1  pattern RAM write enable
- pal_wraddr  out  9  palette RAM address
- pal_wren  out  1  palette RAM write enable
- spr_wraddr  out  6  sprite RAM address
- spr_wren  out  1  sprite RAM write enable
- vram_wrdata  out  64  registered data, shared by all RAMs
- vram_byteena  out  8  registered byte enables, shared by all RAMs
- drop_count  out  DROP_CNT_W  saturating count of dropped writes
- err_oob  out  1  sticky: an address above 0x1A27 was written
- err_overrun  out  1  sticky: cpu_wr_busy was high at vblank_end

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. Every output resets to 0 and the FSM resets to CLOSED.
- Address map, in word addresses:
  - tile 0x0000-0x07FF, local address = addr[10:0]
  - pattern 0x0800-0x17FF, local address = addr - 0x0800
  - palette 0x1800-0x19FF, local address = addr - 0x1800
  - sprite 0x1A00-0x1A27, local address = addr - 0x1A00
  - 0x1A28-0x1FFF is out of bounds.
- FSM states: CLOSED, IRQ, OPEN.
  - CLOSED -> IRQ on vblank_start. Load the IRQ counter with IRQ_LEN.
  - IRQ: cpu_vram_wr_irq=1 and window_open=1; writes are accepted. After IRQ_LEN cycles go to OPEN.
  - OPEN: window_open=1, irq=0. Go to CLOSED on vblank_end.
  - vblank_end while in IRQ also goes to CLOSED and cuts the pulse short.
- Window timing:
  - window_open is registered. It rises the cycle after vblank_start is sampled and falls the cycle after vblank_end is sampled.
- Simultaneous events:
  - vblank_start and vblank_end in the same cycle while CLOSED: vblank_start wins.
  - vblank_start while IRQ or OPEN is ignored.
- Write acceptance: wren is sampled with the current registered state.
  - A write in the vblank_end cycle while OPEN is accepted.
  - A write in the vblank_start cycle while CLOSED is dropped.
- Accepted in-map write:
  - Exactly one region wren is high in the next cycle, for one cycle.
  - The matching local address, vram_wrdata and vram_byteena are valid in that same cycle.
  - Latency is 1 cycle, throughput 1 write per cycle, no backpressure.
- Region enables are never asserted for dropped writes. Address and data registers may update; only the wren signals are significant.
- byteena == 0 counts as a valid write and is forwarded unchanged.
- Dropped writes: a write while CLOSED, or to an out-of-bounds address in any state, increments drop_count. The counter saturates at all ones and does not wrap.
  - An out-of-bounds write also sets err_oob.
  - A write that is both outside the window and out of bounds counts once and sets err_oob.
- err_overrun is set when vblank_end is sampled while in IRQ or OPEN with cpu_wr_busy=1.
- err_oob, err_overrun and drop_count clear only on reset.
- Reset mid-burst: everything returns to 0 immediately and any pending registered write is lost.

Decomposition:
- vram_map_pkg:
  - region base and limit constants: TILE_BASE, PAT_BASE, PAL_BASE, SPR_BASE, SPR_LAST=13'h1A27
  - local address widths
  - typedef enum vram_region_t {REG_TILE, REG_PAT, REG_PAL, REG_SPR, REG_OOB}
  - the FSM state enum
- Sub-module vram_addr_decode: combinational, 13-bit address -> region and local address. It is reusable by the readback path.

Test Plan:
- Window and IRQ: vblank_start pulse at cycle 10 -> irq=1 for cycle 11 only (IRQ_LEN=1); window_open=1 from cycle 11; vblank_end at cycle 500 -> window_open=0 at cycle 501.
- Boundary decode: write each of 0x0000, 0x07FF, 0x0800, 0x17FF, 0x1800, 0x19FF, 0x1A00, 0x1A27 with data 12345 and byteena 0xFF while OPEN.
  - Expected one cycle later: tile 0 / tile 0x7FF / pat 0 / pat 0xFFF / pal 0 / pal 0x1FF / spr 0 / spr 0x27, one wren each.
  - drop_count stays 0.
- Out of bounds: write 0x1A28 and then 0x1FFF while OPEN -> no region wren, drop_count=2, err_oob=1.
- Closed window: 3 writes to 0x0000 before any vblank_start -> no tile_wren, drop_count=3. A write in the vblank_start cycle also counts as dropped; a write in the vblank_end cycle is accepted.
- Overrun and collision:
  - cpu_wr_busy=1 at vblank_end -> err_overrun=1 and window closes.
  - vblank_start and vblank_end in the same cycle from CLOSED -> window opens.
- Saturation and reset: with DROP_CNT_W=4, 20 dropped writes -> drop_count=15. Assert rst_n=0 mid-window -> all outputs 0 asynchronously, and the next vblank_start reopens normally.
